rtc_read_sequencer: RTL and testbench
=====================================

RTC_READ_SEQUENCER -- requirements
Module: rtc_read_sequencer

Interface
REQ-001 The block SHALL have parameter PHASE_LEN, default 4, meaning the number of clk cycles spent in each bus phase; legal values are 1..7.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a read cycle; sampled only in IDLE.
REQ-005 The block SHALL have port addr, input, 8 bits: RTC register address, captured when start is accepted.
REQ-006 The block SHALL have port ad_in, input, 8 bits: the multiplexed address/data bus as read back from the pads.
REQ-007 The block SHALL have port ad_out, output, 8 bits: the value driven onto the address/data bus when ad_oe=1.
REQ-008 The block SHALL have port ad_oe, output, 1 bit: bus output enable, 1 = block drives the pads.
REQ-009 The block SHALL have ports cs_n, ad_n, wr_n and rd_n, outputs, 1 bit each, all active-low: chip select, address/data select (0 = address), write strobe and read strobe.
REQ-010 The block SHALL have port data_out, output, 8 bits: the last byte read from the RTC.
REQ-011 The block SHALL have ports busy and done, outputs, 1 bit each: busy = a cycle is in progress; done = one-cycle pulse marking completion.

Function
REQ-012 The FSM SHALL have the states IDLE, ADDR_SETUP, ADDR_WR, ADDR_HOLD, TURN, DATA_RD and RELEASE.
REQ-013 Each non-IDLE state SHALL last exactly PHASE_LEN cycles, timed by a 3-bit phase counter that clears on every state change; the FSM then advances in the order listed in REQ-012, and RELEASE returns to IDLE.
REQ-014 In IDLE the block SHALL drive cs_n=1, ad_n=1, wr_n=1, rd_n=1, ad_oe=0 and busy=0.
REQ-015 In ADDR_SETUP the block SHALL drive cs_n=0, ad_n=0, ad_oe=1, ad_out=latched addr, wr_n=1 and rd_n=1.
REQ-016 ADDR_WR SHALL drive the same outputs as ADDR_SETUP, except wr_n=0.
REQ-017 ADDR_HOLD SHALL drive the same outputs as ADDR_SETUP (wr_n=1), so the address is held after the WR rising edge.
REQ-018 In TURN the block SHALL drive cs_n=0, ad_n=1, ad_oe=0, wr_n=1 and rd_n=1 (bus turnaround).
REQ-019 In DATA_RD the block SHALL drive cs_n=0, ad_n=1, ad_oe=0 and rd_n=0; data_out SHALL load ad_in on the clock edge that leaves DATA_RD.
REQ-020 In RELEASE the block SHALL drive rd_n=1, cs_n=1, ad_n=1 and ad_oe=0.
REQ-021 busy SHALL be 1 in every non-IDLE state.
REQ-022 All bus control outputs SHALL be registered, so that the strobes are glitch-free.
REQ-023 If start=1 in IDLE at clock edge k, the FSM SHALL enter ADDR_SETUP at edge k and return to IDLE at edge k+6*PHASE_LEN (k+24 with the default), and done SHALL be 1 for exactly the cycle following that edge.
REQ-024 addr SHALL be captured on the accepting edge; changes on addr while busy SHALL have no effect.
REQ-025 start SHALL be ignored while busy=1, with no queuing.
REQ-026 start=1 in the IDLE cycle where done=1 SHALL be accepted, giving back-to-back transfers.
REQ-027 data_out SHALL hold its value between captures and SHALL be unaffected by ad_in outside the capture edge.
REQ-028 wr_n and rd_n SHALL never be 0 in the same cycle.
REQ-029 ad_oe SHALL never be 1 while rd_n=0.

Reset
REQ-030 While reset=0, the block SHALL asynchronously force state IDLE, phase counter 0, cs_n=ad_n=wr_n=rd_n=1, ad_oe=0, ad_out=0, data_out=0, busy=0 and done=0.
REQ-031 Reset asserted mid-cycle, including during ADDR_WR or DATA_RD, SHALL release the strobes immediately, with no capture of data_out.
REQ-032 After reset deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-033 The bench SHALL cover a default read: addr=0x21, ad_in=0x5A in DATA_RD, start at edge 0 -> wr_n low for edges 4..8, rd_n low for edges 16..20, done=1 after edge 24, data_out=0x5A.
REQ-034 The bench SHALL cover start while busy: a second start with addr=0x33 at edge 10 -> ignored, bus still shows 0x21, exactly one done pulse.
REQ-035 The bench SHALL cover back-to-back reads: start held at 1 across the done cycle -> a second cycle begins at once, with a 1-cycle IDLE gap and cs_n=1 during RELEASE.
REQ-036 The bench SHALL cover reset mid-read: reset=0 during DATA_RD -> rd_n=1 and cs_n=1 asynchronously, data_out=0, done never pulses.
REQ-037 The bench SHALL cover PHASE_LEN=1: a full read completes in 6 cycles, and data_out equals ad_in sampled at the DATA_RD exit edge.
REQ-038 The bench SHALL include assertions, checked on all tests, for REQ-028, REQ-029 and "ad_out stable while ad_oe=1".

Source files
------------

// File: rtl/rtc_read_sequencer.sv
// Read-cycle sequencer for a multiplexed-bus RTC: drives address, write strobe,
// turnaround and read strobe phases of PHASE_LEN clocks each, then returns the read byte.
module rtc_read_sequencer #(
  parameter int PHASE_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE, ADDR_SETUP, ADDR_WR, ADDR_HOLD, TURN, DATA_RD, RELEASE
  } state_t;

  localparam logic [2:0] PH_LAST = 3'(PHASE_LEN - 1);

  state_t     state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic       accept, capture;
  logic       cs_n_q, ad_n_q, wr_n_q, rd_n_q, ad_oe_q, busy_q, done_q;
  logic       cs_n_d, ad_n_d, wr_n_d, rd_n_d, ad_oe_d, busy_d, done_d;
  logic [7:0] ad_out_q, data_out_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADDR_SETUP;
          accept  = 1'b1;
        end
      end
      default: begin
        if (phase_q == PH_LAST) begin
          phase_d = 3'd0;
          state_d = (state_q == RELEASE) ? IDLE : state_t'(state_q + 3'd1);
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
    endcase
  end

  // Strobes are decoded from the next state and registered, so the pads see flop outputs only.
  always_comb begin
    cs_n_d  = 1'b1;
    ad_n_d  = 1'b1;
    wr_n_d  = 1'b1;
    rd_n_d  = 1'b1;
    ad_oe_d = 1'b0;
    busy_d  = 1'b1;
    case (state_d)
      IDLE:       busy_d = 1'b0;
      ADDR_SETUP,
      ADDR_HOLD: begin
        cs_n_d  = 1'b0;
        ad_n_d  = 1'b0;
        ad_oe_d = 1'b1;
      end
      ADDR_WR: begin
        cs_n_d  = 1'b0;
        ad_n_d  = 1'b0;
        ad_oe_d = 1'b1;
        wr_n_d  = 1'b0;
      end
      TURN:       cs_n_d = 1'b0;
      DATA_RD: begin
        cs_n_d = 1'b0;
        rd_n_d = 1'b0;
      end
      RELEASE:    ;
      default:    busy_d = 1'b0;
    endcase
    done_d  = (state_q == RELEASE) && (state_d == IDLE);
    capture = (state_q == DATA_RD) && (state_d != DATA_RD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      phase_q    <= 3'd0;
      cs_n_q     <= 1'b1;
      ad_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      ad_oe_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ad_out_q   <= 8'h00;
      data_out_q <= 8'h00;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cs_n_q  <= cs_n_d;
      ad_n_q  <= ad_n_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
      ad_oe_q <= ad_oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (accept)  ad_out_q   <= addr;
      if (capture) data_out_q <= ad_in;
    end
  end

  assign cs_n     = cs_n_q;
  assign ad_n     = ad_n_q;
  assign wr_n     = wr_n_q;
  assign rd_n     = rd_n_q;
  assign ad_oe    = ad_oe_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ad_out   = ad_out_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Bench for rtc_read_sequencer: PHASE_LEN=4 and PHASE_LEN=1 instances against a
// cycle-offset model, plus literal expectations for the directed read scenarios.
module tb_rtc_read_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] addr0 = 8'h00, addr1 = 8'h00, ad_in = 8'hEE;

  logic [7:0] ad_out0, ad_out1, data_out0, data_out1;
  logic       ad_oe0, cs_n0, ad_n0, wr_n0, rd_n0, busy0, done0;
  logic       ad_oe1, cs_n1, ad_n1, wr_n1, rd_n1, busy1, done1;

  int compared = 0;
  int mism = 0;

  always #5 clk = ~clk;

  rtc_read_sequencer #(.PHASE_LEN(4)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .addr(addr0), .ad_in(ad_in),
    .ad_out(ad_out0), .ad_oe(ad_oe0), .cs_n(cs_n0), .ad_n(ad_n0), .wr_n(wr_n0),
    .rd_n(rd_n0), .data_out(data_out0), .busy(busy0), .done(done0));

  rtc_read_sequencer #(.PHASE_LEN(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .addr(addr1), .ad_in(ad_in),
    .ad_out(ad_out1), .ad_oe(ad_oe1), .cs_n(cs_n1), .ad_n(ad_n1), .wr_n(wr_n1),
    .rd_n(rd_n1), .data_out(data_out1), .busy(busy1), .done(done1));

  // Model: a cycle is just a count of edges since acceptance; phase index = count / PHASE_LEN.
  logic       st_a [2];
  logic [7:0] ad_a [2];
  logic [6:0] act_ctl [2];
  logic [7:0] act_dout [2];
  logic [7:0] act_aout [2];
  assign st_a[0] = start0;
  assign st_a[1] = start1;
  assign ad_a[0] = addr0;
  assign ad_a[1] = addr1;
  assign act_ctl[0] = {cs_n0, ad_n0, wr_n0, rd_n0, ad_oe0, busy0, done0};
  assign act_ctl[1] = {cs_n1, ad_n1, wr_n1, rd_n1, ad_oe1, busy1, done1};
  assign act_dout[0] = data_out0;
  assign act_dout[1] = data_out1;
  assign act_aout[0] = ad_out0;
  assign act_aout[1] = ad_out1;

  bit         m_busy [2] = '{0, 0};
  bit         m_done [2] = '{0, 0};
  int         m_t    [2] = '{0, 0};
  logic [7:0] m_addr [2] = '{8'h00, 8'h00};
  logic [7:0] m_data [2] = '{8'h00, 8'h00};

  function automatic int plen(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // bits: cs_n ad_n wr_n rd_n ad_oe busy done
  function automatic logic [6:0] exp_ctl(bit b, int t, int p, bit d);
    if (!b) return {6'b111100, d};
    case (t / p)
      0, 2:    return 7'b0011110;
      1:       return 7'b0001110;
      3:       return 7'b0111010;
      4:       return 7'b0110010;
      default: return 7'b1111010;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_t[i]    <= 0;
        m_addr[i] <= 8'h00;
        m_data[i] <= 8'h00;
      end else if (!m_busy[i]) begin
        m_done[i] <= 1'b0;
        if (st_a[i]) begin
          m_busy[i] <= 1'b1;
          m_t[i]    <= 0;
          m_addr[i] <= ad_a[i];
        end
      end else begin
        m_done[i] <= 1'b0;
        m_t[i]    <= m_t[i] + 1;
        if (m_t[i] + 1 == 5 * plen(i)) m_data[i] <= ad_in;
        if (m_t[i] + 1 == 6 * plen(i)) begin
          m_busy[i] <= 1'b0;
          m_done[i] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [6:0] ec;
      ec = exp_ctl(m_busy[i], m_t[i], plen(i), m_done[i]);
      compared++;
      if (act_ctl[i] !== ec) begin
        mism++;
        $display("FAIL ctl dut%0d t=%0t got %b want %b (cs ad wr rd oe busy done)", i, $time, act_ctl[i], ec);
      end
      compared++;
      if (act_dout[i] !== m_data[i]) begin
        mism++;
        $display("FAIL data_out dut%0d t=%0t got %h want %h", i, $time, act_dout[i], m_data[i]);
      end
      if (ec[2]) begin
        compared++;
        if (act_aout[i] !== m_addr[i]) begin
          mism++;
          $display("FAIL ad_out dut%0d t=%0t got %h want %h", i, $time, act_aout[i], m_addr[i]);
        end
      end
    end
  end

  a_strb0: assert property (@(negedge clk) !(!wr_n0 && !rd_n0))
    else begin mism++; $display("FAIL strobe_overlap dut0 wr_n=%b rd_n=%b", wr_n0, rd_n0); end
  a_strb1: assert property (@(negedge clk) !(!wr_n1 && !rd_n1))
    else begin mism++; $display("FAIL strobe_overlap dut1 wr_n=%b rd_n=%b", wr_n1, rd_n1); end
  a_oe0: assert property (@(negedge clk) !(ad_oe0 && !rd_n0))
    else begin mism++; $display("FAIL oe_during_rd dut0 ad_oe=%b rd_n=%b", ad_oe0, rd_n0); end
  a_oe1: assert property (@(negedge clk) !(ad_oe1 && !rd_n1))
    else begin mism++; $display("FAIL oe_during_rd dut1 ad_oe=%b rd_n=%b", ad_oe1, rd_n1); end
  a_stab0: assert property (@(negedge clk) disable iff (!reset)
                            (ad_oe0 && $past(ad_oe0)) |-> (ad_out0 == $past(ad_out0)))
    else begin mism++; $display("FAIL ad_out_stable dut0 got %h want %h", ad_out0, $past(ad_out0)); end
  a_stab1: assert property (@(negedge clk) disable iff (!reset)
                            (ad_oe1 && $past(ad_oe1)) |-> (ad_out1 == $past(ad_out1)))
    else begin mism++; $display("FAIL ad_out_stable dut1 got %h want %h", ad_out1, $past(ad_out1)); end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    compared++;
    if (got !== want) begin
      mism++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  int dcount;

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("rst_cs_n", {7'd0, cs_n0}, 8'h01);
    chk("rst_wr_rd", {6'd0, wr_n0, rd_n0}, 8'h03);
    chk("rst_oe_busy_done", {5'd0, ad_oe0, busy0, done0}, 8'h00);
    chk("rst_ad_out", ad_out0, 8'h00);
    chk("rst_data_out", data_out1, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Default read
    start0 = 1'b1; addr0 = 8'h21; ad_in = 8'hEE;
    for (int e = 0; e <= 25; e++) begin
      @(negedge clk);
      if (e == 0) start0 = 1'b0;
      case (e)
        0:  chk("rd1_busy_e0", {7'd0, busy0}, 8'h01);
        3:  chk("rd1_wr_n_e3", {7'd0, wr_n0}, 8'h01);
        4:  chk("rd1_wr_n_e4", {7'd0, wr_n0}, 8'h00);
        7:  chk("rd1_wr_n_e7", {7'd0, wr_n0}, 8'h00);
        8:  chk("rd1_wr_n_e8", {7'd0, wr_n0}, 8'h01);
        15: chk("rd1_rd_n_e15", {7'd0, rd_n0}, 8'h01);
        16: chk("rd1_rd_n_e16", {7'd0, rd_n0}, 8'h00);
        19: chk("rd1_rd_n_e19", {7'd0, rd_n0}, 8'h00);
        20: chk("rd1_rd_n_e20", {7'd0, rd_n0}, 8'h01);
        23: chk("rd1_done_e23", {7'd0, done0}, 8'h00);
        24: begin
          chk("rd1_done_e24", {7'd0, done0}, 8'h01);
          chk("rd1_data_out", data_out0, 8'h5A);
        end
        25: chk("rd1_done_e25", {7'd0, done0}, 8'h00);
        default: ;
      endcase
      if (e == 15) ad_in = 8'h5A;
      if (e == 20) ad_in = 8'hEE;
    end
    repeat (3) @(negedge clk);

    // Start while busy
    start0 = 1'b1; addr0 = 8'h21; dcount = 0;
    for (int e = 0; e <= 30; e++) begin
      @(negedge clk);
      if (done0) dcount++;
      if (e == 0)  start0 = 1'b0;
      if (e == 9)  begin start0 = 1'b1; addr0 = 8'h33; end
      if (e == 10) start0 = 1'b0;
      if (e == 11) chk("busy_start_ad_out", ad_out0, 8'h21);
      if (e == 24) chk("busy_start_data", data_out0, 8'hEE);
    end
    chk("busy_start_done_count", 8'(dcount), 8'd1);
    repeat (3) @(negedge clk);

    // Back-to-back reads
    start0 = 1'b1; addr0 = 8'h44;
    for (int e = 0; e <= 50; e++) begin
      @(negedge clk);
      case (e)
        21: chk("b2b_cs_n_release", {7'd0, cs_n0}, 8'h01);
        24: chk("b2b_idle_gap", {6'd0, busy0, done0}, 8'h01);
        25: begin
          chk("b2b_restart_busy", {6'd0, busy0, ad_oe0}, 8'h03);
          chk("b2b_restart_addr", ad_out0, 8'h55);
        end
        49: chk("b2b_second_done", {7'd0, done0}, 8'h01);
        default: ;
      endcase
      if (e == 20) addr0 = 8'h55;
      if (e == 25) start0 = 1'b0;
    end
    repeat (3) @(negedge clk);

    // Reset during DATA_RD, then immediate restart after release
    start0 = 1'b1; addr0 = 8'h21; dcount = 0;
    for (int e = 0; e <= 17; e++) begin
      @(negedge clk);
      if (e == 0) start0 = 1'b0;
      if (e == 17) chk("mid_rd_n_before", {7'd0, rd_n0}, 8'h00);
    end
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_strobes", {6'd0, rd_n0, cs_n0}, 8'h03);
    chk("mid_rst_data_out", data_out0, 8'h00);
    chk("mid_rst_busy", {7'd0, busy0}, 8'h00);
    repeat (2) begin
      @(negedge clk);
      if (done0) dcount++;
    end
    reset = 1'b1; start0 = 1'b1; addr0 = 8'h66;
    @(negedge clk);
    start0 = 1'b0;
    chk("post_rst_accept", {7'd0, busy0}, 8'h01);
    chk("post_rst_addr", ad_out0, 8'h66);
    chk("mid_rst_no_done", 8'(dcount), 8'd0);
    repeat (26) @(negedge clk);

    // PHASE_LEN = 1
    start1 = 1'b1; addr1 = 8'hA7; ad_in = 8'h2F;
    for (int e = 0; e <= 7; e++) begin
      @(negedge clk);
      if (e == 0) start1 = 1'b0;
      case (e)
        1: chk("p1_wr_n", {7'd0, wr_n1}, 8'h00);
        3: chk("p1_turn_oe", {6'd0, ad_oe1, cs_n1}, 8'h00);
        4: chk("p1_rd_n", {7'd0, rd_n1}, 8'h00);
        5: begin
          chk("p1_capture", data_out1, 8'h34);
          chk("p1_release", {6'd0, rd_n1, busy1}, 8'h03);
        end
        6: chk("p1_done", {6'd0, busy1, done1}, 8'h01);
        7: chk("p1_hold", data_out1, 8'h34);
        default: ;
      endcase
      ad_in = 8'h30 + 8'(e);
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
